// File: rtl/inst_fetch.sv
// Instruction fetch stage: small program store with a load port, a prescaled
// program counter, and a valid/ready instruction output that stops on HALT.
module inst_fetch #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int TICK_DIV = 30000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  // Prescaler needs at least one bit even when every cycle is a step.
  localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0]       HALT_OP  = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [31:0]       mem [DEPTH];
  logic [PRE_W-1:0]  presc;
  logic              pending;
  logic              counting;
  logic              tick;
  logic              issue;
  logic              transfer;
  logic              is_halt_word;
  logic [31:0]       rd_word;

  // Step/issue/handshake qualifiers and the word the pc currently points at.
  always_comb begin
    counting     = run && (state != S_HALT);
    tick         = counting && (presc == PRE_LAST);
    issue        = pending && (state == S_RUN) && (!instr_valid || instr_ready);
    transfer     = instr_valid && instr_ready;
    rd_word      = mem[pc_out];
    is_halt_word = (rd_word[31:28] == HALT_OP);
  end

  // Next-state: HALT is entered on the same edge the HALT word is fetched,
  // so no further issue can follow it even when stepping every cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_RUN;
        else     state_next = S_IDLE;
      end
      S_RUN: begin
        if (!run)                      state_next = S_IDLE;
        else if (issue && is_halt_word) state_next = S_HALT;
        else                           state_next = S_RUN;
      end
      S_HALT: begin
        if (!run) state_next = S_IDLE;
        else      state_next = S_HALT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Program store write port; loads are only accepted outside run mode and
  // the contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (load_en && !run) mem[load_addr] <= load_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Prescaler: free-runs while stepping is enabled, frozen in HALT.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      presc <= '0;
    end else if (counting) begin
      if (tick) presc <= '0;
      else      presc <= presc + PRE_W'(1);
    end
  end

  // One-deep step request; a tick arriving while one is waiting is lost,
  // and a tick on the issue cycle re-arms it.
  always_ff @(posedge clk) begin
    if (rst || !run) pending <= 1'b0;
    else if (tick)   pending <= 1'b1;
    else if (issue)  pending <= 1'b0;
  end

  // Fetch and output register: the store read lands directly in instr_out,
  // so an issue coinciding with a transfer keeps valid high back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out   <= 32'h0000_0000;
      instr_valid <= 1'b0;
      pc_out      <= '0;
    end else if (issue) begin
      instr_out   <= rd_word;
      instr_valid <= 1'b1;
      pc_out      <= pc_out + ADDR_W'(1);
    end else if (transfer) begin
      instr_valid <= 1'b0;
    end
  end

  // Halted flag mirrors the registered HALT state.
  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else     halted <= (state_next == S_HALT);
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: one instance at TICK_DIV=4, one at 1.
module tb_inst_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        run, load_en, instr_ready;
  logic [2:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] instr_out;
  logic        instr_valid, halted;
  logic [2:0]  pc_out;

  logic        run1, load_en1, instr_ready1;
  logic [2:0]  load_addr1;
  logic [31:0] load_data1;
  logic [31:0] instr_out1;
  logic        instr_valid1, halted1;
  logic [2:0]  pc_out1;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb  [$];
  logic [31:0] sb1 [$];

  inst_fetch #(.DEPTH(8), .ADDR_W(3), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .run(run), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_out(pc_out), .halted(halted)
  );

  inst_fetch #(.DEPTH(8), .ADDR_W(3), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .run(run1), .load_en(load_en1), .load_addr(load_addr1),
    .load_data(load_data1), .instr_out(instr_out1), .instr_valid(instr_valid1),
    .instr_ready(instr_ready1), .pc_out(pc_out1), .halted(halted1)
  );

  // All tasks start and end just after a falling edge.
  task automatic load_word(input bit sel, input logic [2:0] a, input logic [31:0] d);
    if (sel) begin load_en1 = 1'b1; load_addr1 = a; load_data1 = d; end
    else     begin load_en  = 1'b1; load_addr  = a; load_data  = d; end
    @(negedge clk);
    load_en  = 1'b0;
    load_en1 = 1'b0;
  endtask

  task automatic do_reset();
    run = 1'b0; instr_ready = 1'b0; run1 = 1'b0; instr_ready1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (pc_out !== 3'd0) begin miscompares++; $display("FAIL reset_pc: got %0d expected 0", pc_out); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    vectors++; if (instr_out !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 00000000", instr_out); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b expected 0", halted); end
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    int cyc = 0;
    int last = -1;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) load_word(1'b0, 3'(i), 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 9; i++) sb.push_back(32'h1000_0000 + 32'(i % 8));
    run = 1'b1; instr_ready = 1'b1;
    while (sb.size() > 0 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (instr_valid) begin
        exp = sb.pop_front();
        vectors++; if (instr_out !== exp) begin miscompares++; $display("FAIL seq_word: got %h expected %h", instr_out, exp); end
        if (last < 0) begin
          vectors++; if (cyc != 5) begin miscompares++; $display("FAIL first_latency: got %0d cycles expected 5", cyc); end
        end else begin
          vectors++; if (cyc - last != 4) begin miscompares++; $display("FAIL step_interval: got %0d expected 4", cyc - last); end
        end
        last = cyc;
      end
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL seq_timeout: got %0d words left expected 0", sb.size()); sb.delete(); end
    run = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    bit drop_chk;
    logic [31:0] exp;
    sb.push_back(32'h1000_0000);
    sb.push_back(32'h1000_0001);
    sb.push_back(32'h1000_0002);
    run = 1'b1; instr_ready = 1'b0;
    while (!instr_valid && cyc < 50) begin @(negedge clk); cyc++; end
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL bp_first_valid: got %b expected 1", instr_valid); end
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (instr_valid !== 1'b1 || instr_out !== sb[0]) begin
        miscompares++; $display("FAIL bp_hold: got valid %b data %h expected 1 %h", instr_valid, instr_out, sb[0]);
      end
      @(negedge clk);
    end
    instr_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 50) begin
      drop_chk = 1'b0;
      if (instr_valid) begin
        exp = sb.pop_front();
        vectors++; if (instr_out !== exp) begin miscompares++; $display("FAIL bp_word: got %h expected %h", instr_out, exp); end
        drop_chk = (exp == 32'h1000_0001);
      end
      @(negedge clk); cyc++;
      if (drop_chk) begin
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL bp_one_tick_buffered: got valid %b expected 0", instr_valid); end
      end
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL bp_timeout: got %0d words left expected 0", sb.size()); sb.delete(); end
    run = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_halt();
    int cyc = 0;
    int extra = 0;
    logic [31:0] exp;
    load_word(1'b0, 3'd2, 32'hE000_0000);
    sb.push_back(32'h1000_0000);
    sb.push_back(32'h1000_0001);
    sb.push_back(32'hE000_0000);
    run = 1'b1; instr_ready = 1'b1;
    while (sb.size() > 0 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (instr_valid) begin
        exp = sb.pop_front();
        vectors++; if (instr_out !== exp) begin miscompares++; $display("FAIL halt_word: got %h expected %h", instr_out, exp); end
      end
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL halt_timeout: got %0d words left expected 0", sb.size()); sb.delete(); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (instr_valid) extra++;
    end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL halt_no_more_valid: got %0d valids expected 0", extra); end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag: got %b expected 1", halted); end
    vectors++; if (pc_out !== 3'd3) begin miscompares++; $display("FAIL halt_pc: got %0d expected 3", pc_out); end
    run = 1'b0;
    @(negedge clk);
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_clear: got %b expected 0", halted); end
    vectors++; if (pc_out !== 3'd3) begin miscompares++; $display("FAIL halt_pc_held: got %0d expected 3", pc_out); end
    instr_ready = 1'b0;
  endtask

  task automatic test_load_ignored_and_reset();
    int cyc = 0;
    run = 1'b1; instr_ready = 1'b0;
    load_word(1'b0, 3'd0, 32'hDEAD_BEEF);
    while (!instr_valid && cyc < 50) begin @(negedge clk); cyc++; end
    vectors++; if (instr_valid !== 1'b1 || instr_out !== 32'h1000_0000) begin
      miscompares++; $display("FAIL load_ignored: got valid %b data %h expected 1 10000000", instr_valid, instr_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b expected 0", instr_valid); end
    vectors++; if (pc_out !== 3'd0) begin miscompares++; $display("FAIL midreset_pc: got %0d expected 0", pc_out); end
    rst = 1'b0; run = 1'b1; instr_ready = 1'b1;
    sb.push_back(32'h1000_0000);
    cyc = 0;
    while (sb.size() > 0 && cyc < 50) begin
      @(negedge clk); cyc++;
      if (instr_valid) begin
        vectors++;
        if (instr_out !== sb[0]) begin miscompares++; $display("FAIL store_intact: got %h expected %h", instr_out, sb[0]); end
        void'(sb.pop_front());
      end
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL store_timeout: got %0d words left expected 0", sb.size()); sb.delete(); end
    run = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) load_word(1'b1, 3'(i), 32'h2000_0000 + 32'(i));
    for (int i = 0; i < 16; i++) sb1.push_back(32'h2000_0000 + 32'(i % 8));
    run1 = 1'b1; instr_ready1 = 1'b1;
    while (!instr_valid1 && cyc < 20) begin @(negedge clk); cyc++; end
    vectors++; if (instr_valid1 !== 1'b1) begin miscompares++; $display("FAIL b2b_first_valid: got %b expected 1", instr_valid1); end
    for (int k = 0; k < 16; k++) begin
      exp = sb1.pop_front();
      vectors++;
      if (instr_valid1 !== 1'b1 || instr_out1 !== exp) begin
        miscompares++; $display("FAIL b2b_word: got valid %b data %h expected 1 %h", instr_valid1, instr_out1, exp);
      end
      @(negedge clk);
    end
    run1 = 1'b0; instr_ready1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0; load_en = 1'b0; load_addr = 3'd0; load_data = 32'h0; instr_ready = 1'b0;
    run1 = 1'b0; load_en1 = 1'b0; load_addr1 = 3'd0; load_data1 = 32'h0; instr_ready1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence();
    do_reset();
    test_backpressure();
    do_reset();
    test_halt();
    do_reset();
    test_load_ignored_and_reset();
    do_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of run expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
